// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the ADC scan sequencer
package spi_pkg;

    localparam int DefWidth = 12;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_START,
        ST_WAIT_EOR,
        ST_STORE,
        ST_ABORT
    } state_e;

endpackage

// File: rtl/spi_scan_ctrl_if.sv
// rtl/spi_scan_ctrl_if.sv - handshake between the scan sequencer and the SPI reader
interface spi_scan_ctrl_if
    import spi_pkg::*;
#(
    parameter int Width = DefWidth
);
    logic             strr;
    logic             ch;
    logic             eor;
    logic [Width-1:0] dout;

    modport master (output strr, output ch, input eor, input dout);
    modport slave  (input strr, input ch, output eor, output dout);
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running period counter, held at zero while disabled
module tick_gen #(
    parameter int Period = 5000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [CW-1:0] Last = CW'(Period - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == Last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == Last);
endmodule

// File: rtl/spi_scan_ctrl.sv
// rtl/spi_scan_ctrl.sv - paced two-channel ADC read sequencer with timeout and overrun flags
module spi_scan_ctrl
    import spi_pkg::*;
#(
    parameter int Width      = DefWidth,
    parameter int PeriodCyc  = 5000,
    parameter int TimeoutCyc = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    spi_scan_ctrl_if.master        rd,
    output logic [Width-1:0]       ch0_o,
    output logic [Width-1:0]       ch1_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic                   ovr_o
);
    localparam int TW = $clog2(TimeoutCyc);
    localparam logic [TW-1:0] TmoLast = TW'(TimeoutCyc - 1);

    state_e           state_q;
    logic [TW-1:0]    tmo_q;
    logic [Width-1:0] dlat_q, ch0_q, ch1_q;
    logic             cap_ch_q, strr_q, ch_q, valid_q, busy_q, err_q, ovr_q;
    logic             tick;

    tick_gen #(.Period(PeriodCyc)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            dlat_q   <= '0;
            ch0_q    <= '0;
            ch1_q    <= '0;
            cap_ch_q <= CH0;
            strr_q   <= 1'b0;
            ch_q     <= CH0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            strr_q  <= 1'b0;
            valid_q <= 1'b0;
            if (tick && busy_q) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (en_i) state_q <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!en_i) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        state_q <= ST_START;
                        strr_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_EOR;
                end
                ST_WAIT_EOR: begin
                    // Channel flips at end-of-read so it is already settled the cycle before the next strobe.
                    if (rd.eor) begin
                        dlat_q   <= rd.dout;
                        cap_ch_q <= ch_q;
                        ch_q     <= ~ch_q;
                        state_q  <= ST_STORE;
                    end else if (tmo_q == TmoLast) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ABORT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (cap_ch_q == CH0) begin
                        ch0_q   <= dlat_q;
                        strr_q  <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        ch1_q   <= dlat_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= en_i ? ST_WAIT_TICK : ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    ch_q    <= CH0;
                    busy_q  <= 1'b0;
                    state_q <= en_i ? ST_WAIT_TICK : ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd.strr = strr_q;
    assign rd.ch   = ch_q;
    assign ch0_o   = ch0_q;
    assign ch1_o   = ch1_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;
    assign ovr_o   = ovr_q;
endmodule

// File: tb/tb_spi_scan_ctrl.sv
// tb/tb_spi_scan_ctrl.sv - directed bench for spi_scan_ctrl with a latency-programmable reader model
module tb_spi_scan_ctrl;
    localparam int W = 12;
    localparam int P = 60;
    localparam int T = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [W-1:0] ch0, ch1;
    logic         valid, busy, err, ovr;

    spi_scan_ctrl_if #(.Width(W)) bus ();

    spi_scan_ctrl #(.Width(W), .PeriodCyc(P), .TimeoutCyc(T)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .rd      (bus.master),
        .ch0_o   (ch0),
        .ch1_o   (ch1),
        .valid_o (valid),
        .busy_o  (busy),
        .err_o   (err),
        .ovr_o   (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           total = 0;
    int           bad   = 0;
    int           lat   = 20;
    bit           drop_ch1 = 1'b0;
    logic [W-1:0] data0 = 12'hABC;
    logic [W-1:0] data1 = 12'h123;

    // Reader model: end-of-read arrives lat cycles after the strobe; dout is junk outside eor.
    int   rd_cnt = 0;
    logic rd_ch  = 1'b0;
    initial begin
        bus.eor  = 1'b0;
        bus.dout = 12'hEEE;
        forever begin
            @(posedge clk);
            #1;
            bus.eor  = 1'b0;
            bus.dout = 12'hEEE;
            if (rst) begin
                rd_cnt = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        bus.eor  = 1'b1;
                        bus.dout = rd_ch ? data1 : data0;
                    end
                end
                if (bus.strr && !(bus.ch && drop_ch1)) begin
                    rd_cnt = lat;
                    rd_ch  = bus.ch;
                end
            end
        end
    end

    int   strr_cnt = 0;
    int   valid_cnt = 0;
    int   strr_t[16];
    logic strr_c[16];
    int   valid_t[16];
    always @(negedge clk) begin
        if (bus.strr) begin
            if (strr_cnt < 16) begin
                strr_t[strr_cnt] = cyc;
                strr_c[strr_cnt] = bus.ch;
            end
            strr_cnt++;
        end
        if (valid) begin
            if (valid_cnt < 16) valid_t[valid_cnt] = cyc;
            valid_cnt++;
        end
    end

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(int t);
        int n = t - cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        drop_ch1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        strr_cnt  = 0;
        valid_cnt = 0;
    endtask

    int k;

    initial begin
        do_reset();
        check_eq("rst_strr",  32'(bus.strr), 0);
        check_eq("rst_ch",    32'(bus.ch),   0);
        check_eq("rst_ch0",   32'(ch0),      0);
        check_eq("rst_ch1",   32'(ch1),      0);
        check_eq("rst_valid", 32'(valid),    0);
        check_eq("rst_busy",  32'(busy),     0);
        check_eq("rst_err",   32'(err),      0);
        check_eq("rst_ovr",   32'(ovr),      0);

        // Normal pacing, latency 20.
        lat = 20; data0 = 12'hABC; data1 = 12'h123;
        en = 1'b1; k = cyc;
        wait_until(k + 70);
        check_eq("n_busy_mid", 32'(busy),   1);
        check_eq("n_ch_rd0",   32'(bus.ch), 0);
        wait_until(k + 90);
        check_eq("n_ch_rd1",   32'(bus.ch), 1);
        wait_until(k + 230);
        check_eq("n_valid_cnt", valid_cnt, 3);
        check_eq("n_strr_cnt",  strr_cnt,  6);
        check_eq("n_ch0",       32'(ch0),  32'hABC);
        check_eq("n_ch1",       32'(ch1),  32'h123);
        check_eq("n_err",       32'(err),  0);
        check_eq("n_ovr",       32'(ovr),  0);
        check_eq("n_first_strr", strr_t[0] - k, 60);
        check_eq("n_period",     strr_t[2] - strr_t[0], 60);
        check_eq("n_strr2_gap",  strr_t[1] - strr_t[0], 22);
        check_eq("n_valid_lat",  valid_t[0] - strr_t[0], 44);
        check_eq("n_valid_per",  valid_t[1] - valid_t[0], 60);
        check_eq("n_strr_ch0",   32'(strr_c[0]), 0);
        check_eq("n_strr_ch1",   32'(strr_c[1]), 1);

        // Reader goes silent on ch1 of the second scan.
        do_reset();
        lat = 20; data0 = 12'hABC; data1 = 12'h123;
        en = 1'b1; k = cyc;
        wait_until(k + 110);
        check_eq("t_valid1", valid_cnt, 1);
        data0 = 12'h456; drop_ch1 = 1'b1;
        wait_until(k + 190);
        check_eq("t_err_before", 32'(err), 0);
        wait_until(k + 191);
        check_eq("t_err_at", 32'(err), 1);
        wait_until(k + 200);
        check_eq("t_ch1_kept", 32'(ch1),    32'h123);
        check_eq("t_ch0_new",  32'(ch0),    32'h456);
        check_eq("t_no_valid", valid_cnt,   1);
        check_eq("t_ch_back",  32'(bus.ch), 0);
        drop_ch1 = 1'b0; data1 = 12'h321;
        wait_until(k + 300);
        check_eq("t_valid2",     valid_cnt, 2);
        check_eq("t_ch1_after",  32'(ch1), 32'h321);
        check_eq("t_restart_ch", 32'(strr_c[4]), 0);
        check_eq("t_restart_t",  strr_t[4] - k, 240);

        // Scan longer than the period.
        do_reset();
        lat = 30; data0 = 12'h0F1; data1 = 12'hF0E;
        en = 1'b1; k = cyc;
        wait_until(k + 118);
        check_eq("o_ovr_before", 32'(ovr), 0);
        wait_until(k + 120);
        check_eq("o_ovr_set", 32'(ovr), 1);
        wait_until(k + 290);
        check_eq("o_valid_cnt", valid_cnt, 2);
        check_eq("o_strr_cnt",  strr_cnt,  4);
        check_eq("o_err",       32'(err),  0);
        check_eq("o_ch0",       32'(ch0),  32'h0F1);
        check_eq("o_ch1",       32'(ch1),  32'hF0E);

        // Enable dropped between the two reads.
        do_reset();
        lat = 20; data0 = 12'hABC; data1 = 12'h123;
        en = 1'b1; k = cyc;
        wait_until(k + 70);
        en = 1'b0;
        wait_until(k + 200);
        check_eq("e_valid_cnt", valid_cnt, 1);
        check_eq("e_strr_cnt",  strr_cnt,  2);
        check_eq("e_busy",      32'(busy), 0);
        check_eq("e_ch1",       32'(ch1),  32'h123);

        // End-of-read lands on the last timeout cycle.
        do_reset();
        lat = T; data0 = 12'h3C3; data1 = 12'hC3C;
        en = 1'b1; k = cyc;
        wait_until(k + 170);
        check_eq("c_err",   32'(err), 0);
        check_eq("c_valid", valid_cnt, 1);
        check_eq("c_ch0",   32'(ch0), 32'h3C3);
        check_eq("c_ch1",   32'(ch1), 32'hC3C);

        // Asynchronous reset while waiting for ch1's end-of-read.
        do_reset();
        lat = 20; data0 = 12'hABC; data1 = 12'h123;
        en = 1'b1; k = cyc;
        wait_until(k + 87);
        check_eq("a_ch0_pre",  32'(ch0),    32'hABC);
        check_eq("a_ch_pre",   32'(bus.ch), 1);
        check_eq("a_busy_pre", 32'(busy),   1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("a_ch0",  32'(ch0),      0);
        check_eq("a_ch",   32'(bus.ch),   0);
        check_eq("a_busy", 32'(busy),     0);
        check_eq("a_strr", 32'(bus.strr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        strr_cnt = 0;
        k = cyc;
        wait_until(k + 59);
        check_eq("a_no_strr", strr_cnt, 0);
        wait_until(k + 61);
        check_eq("a_strr_cnt", strr_cnt, 1);
        check_eq("a_strr_t",   strr_t[0] - k, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/spi_scan_ctrl.md
# spi_scan_ctrl

Sequencer for the two-channel ADC read path. It paces conversions with a programmable sample-period timer and, per sample tick, reads channel 0 then channel 1: it selects the channel, pulses the reader's start strobe and waits for end-of-read. It captures each 12-bit result into a per-channel holding register and flags completion of a channel pair. It sits between the system logic and the SPI read datapath, which drives `eor_i`/`dout_i` back to it, and is the only driver of that datapath's start strobe.

## Interface
- `Width`, 12, result width captured from the reader.
- `PeriodCyc`, 5000, clk_i cycles between sample ticks (≥ 2).
- `TimeoutCyc`, 1024, max clk_i cycles from strobe to `eor_i` before abort (≥ 2).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  level; enables the period timer and scanning.
- `eor_i`  in  1  end-of-read pulse from the reader (one cycle).
- `dout_i`  in  Width  reader result, valid in the cycle `eor_i` = 1.
- `strr_o`  out  1  start-read strobe to the reader (one-cycle pulse).
- `ch_o`  out  1  channel select for the current read (0/1).
- `ch0_o`  out  Width  last channel-0 result.
- `ch1_o`  out  Width  last channel-1 result.
- `valid_o`  out  1  one-cycle pulse: both channel registers updated by this scan.
- `busy_o`  out  1  high while a scan is in progress (any state but IDLE/WAIT_TICK).
- `err_o`  out  1  sticky: a read timed out; cleared only by reset.
- `ovr_o`  out  1  sticky: a tick arrived while busy; cleared only by reset.

## Operation
- Period timer: counts 0..PeriodCyc-1 while `en_i` = 1 and wraps. `tick` is asserted when the count = PeriodCyc-1. While `en_i` = 0 the timer is held at 0.
- FSM states:
  - IDLE → WAIT_TICK when `en_i` = 1.
  - WAIT_TICK → START on `tick`. Returns to IDLE if `en_i` = 0.
  - START: `strr_o` = 1 for exactly one cycle; the timeout counter is cleared. → WAIT_EOR.
  - WAIT_EOR:
    - `eor_i` = 1 → STORE.
    - timeout counter reaches TimeoutCyc-1 → ABORT.
  - STORE: the result captured from `dout_i` is written to `ch0_o` or `ch1_o` per `ch_o`.
    - `ch_o` = 0 → set `ch_o` = 1, go to START.
    - `ch_o` = 1 → pulse `valid_o`, set `ch_o` = 0, go to WAIT_TICK (or IDLE if `en_i` = 0).
  - ABORT: set `err_o`, leave the channel register unchanged, set `ch_o` = 0, no `valid_o`. → WAIT_TICK/IDLE.
- `dout_i` is latched in the cycle `eor_i` = 1 (WAIT_EOR); the holding register is written in STORE from that latch.
- `en_i` falling mid-scan: the scan completes (or aborts) normally, then the FSM goes to IDLE.
- `tick` while busy: the tick is dropped and `ovr_o` is set.
- `eor_i` and timeout in the same cycle: `eor_i` wins (STORE, no error).
- `eor_i` outside WAIT_EOR is ignored.

## Timing
- Reset values: `strr_o` = 0, `ch_o` = 0, `ch0_o` = `ch1_o` = 0, `valid_o` = 0, `busy_o` = 0, `err_o` = 0, `ovr_o` = 0. FSM = IDLE, timer = 0.
- All outputs are registered.
- `strr_o` rises 1 cycle after the `tick` cycle.
- `ch_o` is stable from 1 cycle before `strr_o` through the matching `eor_i`.
- Channel register updates 2 cycles after its `eor_i`.
- `valid_o` pulses 2 cycles after channel-1 `eor_i`, in the same cycle `ch1_o` updates.
- Second strobe: `strr_o` for ch1 asserts 2 cycles after ch0's `eor_i`.
- Minimum scan length: 2×(reader latency + 3) cycles. PeriodCyc must exceed this or `ovr_o` will set.

## Structure
- Shared package `spi_pkg`:
  - FSM state encoding (IDLE, WAIT_TICK, START, WAIT_EOR, STORE, ABORT).
  - channel indices CH0/CH1.
  - default Width.
- Sub-module `tick_gen`: parameterised period counter with enable, output `tick`; reusable by other paced blocks.
- Top: FSM, timeout counter, `dout_i` latch, two holding registers, sticky flags.

## Test plan
- Reset, `en_i` = 1, reader model returns ch0 = 0xABC and ch1 = 0x123, each `eor_i` 20 cycles after `strr_o` → `ch0_o` = 0xABC, `ch1_o` = 0x123, one `valid_o` per tick, `strr_o` period = PeriodCyc.
- Reader never asserts `eor_i` on ch1 → `err_o` = 1 after TimeoutCyc cycles, `ch1_o` unchanged, no `valid_o`, next tick restarts at ch0.
- PeriodCyc = 30 with reader latency 20 → `ovr_o` = 1, scans still complete, `valid_o` on every completed scan.
- `en_i` dropped between ch0 and ch1 reads → ch1 read completes, `valid_o` pulses, FSM idle, no further `strr_o`.
- `eor_i` coincident with timeout expiry → STORE taken, `err_o` stays 0.
- `rst_i` asserted asynchronously during WAIT_EOR → all outputs 0 immediately; no `strr_o` until the first tick after reset release with `en_i` = 1.
